// File: rtl/instr_reader.sv
// instr_reader: read-side checking sequencer for the 32-entry instruction register.
// On an accepted start it sweeps read_pointer over [first_ptr..last_ptr] (with
// wrap-around), waits out the register's one-cycle read latency, recomputes each
// entry's expected result from opcode/operands and tallies pass/fail/skip.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start                    sweep request pulse (ignored while busy)
//   first_ptr, last_ptr      sweep range, sampled on an accepted start
//   read_pointer             address to the instruction register (registered)
//   instruction_word         {opc[3:0], op_a[31:0], op_b[31:0], result[63:0]}
//   busy, done               sweep in progress / one-cycle completion pulse
//   pass/fail/skip_count     per-sweep tallies, saturating at DEPTH
//   err_valid, err_addr      per-mismatch strobe and its address
//   fail_map                 sticky per-address fail bitmap
//
// Build option: define INSTR_READER_FAIL_MAP_EN to build fail_map storage;
// otherwise fail_map is tied to zero.

module instr_reader #(
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AW-1:0]     first_ptr,
  input  logic [AW-1:0]     last_ptr,
  output logic [AW-1:0]     read_pointer,
  input  logic [131:0]      instruction_word,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       pass_count,
  output logic [AW:0]       fail_count,
  output logic [AW:0]       skip_count,
  output logic              err_valid,
  output logic [AW-1:0]     err_addr,
  output logic [DEPTH-1:0]  fail_map
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   last_q;
  logic            v1_q, v2_q;
  logic [AW-1:0]   addr2_q;
  logic            accept;

  logic [3:0]         opc;
  logic signed [63:0] a_ext, b_ext, b_div, exp_res, res;
  logic               b_zero, is_skip, is_fail;

  assign accept = (state_q == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (read_pointer == last_q) state_d = DRAIN;
      DRAIN:   if (v2_q && !v1_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Expected-result model for the entry currently at the second pipeline stage
  always_comb begin
    opc    = instruction_word[131:128];
    a_ext  = 64'($signed(instruction_word[127:96]));
    b_ext  = 64'($signed(instruction_word[95:64]));
    res    = $signed(instruction_word[63:0]);
    b_zero = (instruction_word[95:64] == '0);
    // Divisor substituted when zero so the divider never sees 0; such entries are skipped.
    b_div  = b_zero ? 64'sd1 : b_ext;
    case (opc)
      4'd0:    exp_res = '0;
      4'd1:    exp_res = a_ext;
      4'd2:    exp_res = b_ext;
      4'd3:    exp_res = a_ext + b_ext;
      4'd4:    exp_res = a_ext - b_ext;
      4'd5:    exp_res = a_ext * b_ext;
      4'd6:    exp_res = a_ext / b_div;
      4'd7:    exp_res = a_ext % b_div;
      default: exp_res = '0;
    endcase
    is_skip = ((opc == 4'd6) || (opc == 4'd7)) && b_zero;
    is_fail = !is_skip && (opc[3] || (res != exp_res));
  end

  // Address issue, check pipeline and tallies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      last_q       <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      addr2_q      <= '0;
      done         <= 1'b0;
      pass_count   <= '0;
      fail_count   <= '0;
      skip_count   <= '0;
      err_valid    <= 1'b0;
      err_addr     <= '0;
    end else begin
      done      <= (state_q == DRAIN) && (state_d == IDLE);
      err_valid <= 1'b0;
      v2_q      <= v1_q;
      addr2_q   <= read_pointer;

      if (accept) begin
        last_q       <= last_ptr;
        read_pointer <= first_ptr;
        v1_q         <= 1'b1;
        pass_count   <= '0;
        fail_count   <= '0;
        skip_count   <= '0;
      end else if (state_q == SWEEP) begin
        // Stop on reaching last_q rather than counting, so first==last is one entry.
        if (read_pointer == last_q) begin
          v1_q <= 1'b0;
        end else begin
          read_pointer <= read_pointer + AW'(1);
          v1_q         <= 1'b1;
        end
      end else begin
        v1_q <= 1'b0;
      end

      if (v2_q) begin
        if (is_skip) begin
          if (skip_count != CNT_MAX) skip_count <= skip_count + 1'b1;
        end else if (is_fail) begin
          if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
          err_valid <= 1'b1;
          err_addr  <= addr2_q;
        end else begin
          if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
        end
      end
    end
  end

`ifdef INSTR_READER_FAIL_MAP_EN
  logic [DEPTH-1:0] fail_map_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_map_q <= '0;
    end else if (accept) begin
      fail_map_q <= '0;
    end else if (v2_q && is_fail) begin
      fail_map_q[addr2_q] <= 1'b1;
    end
  end

  assign fail_map = fail_map_q;
`else
  assign fail_map = '0;
`endif

endmodule
